uart_tx_fifo: RTL and testbench

//  Byte FIFO that sits directly upstream of the UART transmitter. Producers
//  (keyboard scan logic, host bridge) push bytes at any rate up to one per clock.
//  The block drains the FIFO into the UART's wr_i/dat_i/tx_bsy_o handshake.
//  It absorbs bursts while the UART serialises at 115200 baud.

---
 rtl/uart_tx_fifo.sv | 143 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART wr_i/dat_i/tx_bsy_o handshake.
// Optional CR insertion before LF: define UART_TX_FIFO_CRLF_EN.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_i,
  input  logic [7:0]            dat_i,
  input  logic                  ovf_clr_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  ovf_o,
  output logic                  uart_wr_o,
  output logic [7:0]            uart_dat_o,
  input  logic                  uart_bsy_i
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] CNT_ONE = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

  typedef enum logic {
    S_IDLE,
    S_STROBE
  } state_t;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_ovf;
  logic                  r_uart_wr;
  logic [7:0]            r_uart_dat;
  state_t                r_state;

  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_send;
  logic       w_pop;
  logic       w_ins_cr;
  logic [7:0] w_head;
  logic [7:0] w_send_dat;

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rd_ptr];
  assign w_push  = wr_i & ~w_full;
  assign w_send  = (r_state == S_IDLE) & ~w_empty & ~uart_bsy_i;
  assign w_pop   = w_send & ~w_ins_cr;

`ifdef UART_TX_FIFO_CRLF_EN
  logic r_cr_pend;

  // LF at the head is held back one send so a CR can go out first
  assign w_ins_cr   = (w_head == 8'h0A) & ~r_cr_pend;
  assign w_send_dat = w_ins_cr ? 8'h0D : w_head;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cr_pend <= 1'b0;
    end else if (w_send) begin
      r_cr_pend <= w_ins_cr;
    end
  end
`else
  assign w_ins_cr   = 1'b0;
  assign w_send_dat = w_head;
`endif

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= dat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      // a dropped push wins over a clear in the same cycle
      if (wr_i & w_full) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr_i) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_uart_wr  <= 1'b0;
      r_uart_dat <= 8'h00;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_send) begin
            r_uart_wr  <= 1'b1;
            r_uart_dat <= w_send_dat;
            r_state    <= S_STROBE;
          end else begin
            r_uart_wr <= 1'b0;
          end
        end
        S_STROBE: begin
          // gives the UART one cycle to raise tx_bsy_o
          r_uart_wr <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_uart_wr <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign full_o     = w_full;
  assign empty_o    = w_empty;
  assign count_o    = r_count;
  assign ovf_o      = r_ovf;
  assign uart_wr_o  = r_uart_wr;
  assign uart_dat_o = r_uart_dat;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected UART bytes,
// a negedge monitor pops and compares on every uart_wr_o strobe.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic       wr;
  logic [7:0] dat;
  logic       ovf_clr;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       ovf;
  logic       uart_wr;
  logic [7:0] uart_dat;
  logic       uart_bsy;

  logic       auto_uart;
  logic       bsy_man;
  int         bcnt;

  logic [7:0] exp_q[$];
  int         n_cmp;
  int         n_err;
  int         n_strobe;
  logic       prev_wr;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_i       (wr),
    .dat_i      (dat),
    .ovf_clr_i  (ovf_clr),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count),
    .ovf_o      (ovf),
    .uart_wr_o  (uart_wr),
    .uart_dat_o (uart_dat),
    .uart_bsy_i (uart_bsy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART model: busy from the edge after a strobe, for 4 cycles
  always @(posedge clk) begin
    if (uart_wr) bcnt <= 4;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign uart_bsy = auto_uart ? (bcnt != 0) : bsy_man;

  always @(negedge clk) begin
    if (uart_wr) begin
      n_strobe++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: got %02h, none expected", uart_dat);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (uart_dat !== e) begin
          n_err++;
          $display("FAIL uart_byte: got %02h, expected %02h", uart_dat, e);
        end
      end
      n_cmp++;
      if (prev_wr) begin
        n_err++;
        $display("FAIL back_to_back: got 2 strobes in a row, expected 1");
      end
    end
    prev_wr = uart_wr;
  end

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  task automatic push(input logic [7:0] b, input bit keep);
    wr  = 1'b1;
    dat = b;
    if (keep) exp_q.push_back(b);
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wait_drain(input string nm, input int maxc);
    int i;
    for (i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && empty && !uart_wr) break;
    end
    n_cmp++;
    if (i == maxc) begin
      n_err++;
      $display("FAIL %s: got %0d bytes pending, expected 0", nm, exp_q.size());
    end
  endtask

  initial begin
    int s0;
    bit found;
    n_cmp = 0; n_err = 0; n_strobe = 0; prev_wr = 1'b0;
    rst = 1'b1; wr = 1'b0; dat = 8'h00; ovf_clr = 1'b0;
    auto_uart = 1'b0; bsy_man = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_uart_wr", uart_wr, 0);
    chk("rst_uart_dat", uart_dat, 0);

    // 1: single byte latency
    push(8'h41, 1);
    chk("lat_wr_1clk", uart_wr, 0);
    @(negedge clk);
    chk("lat_wr_2clk", uart_wr, 1);
    @(negedge clk);
    chk("lat_wr_pulse", uart_wr, 0);
    chk("lat_empty", empty, 1);

    // 2: fill while busy, overflow, clear
    bsy_man = 1'b1;
    for (int k = 0; k < 16; k++) push(k[7:0], 1);
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_ovf", ovf, 0);
    push(8'hFF, 0);
    chk("ovf_set", ovf, 1);
    chk("ovf_count", count, 16);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 0);

    // 3: drain with the UART model
    auto_uart = 1'b1;
    wait_drain("drain16", 400);
    chk("drain_count", count, 0);

    // 4: push into a full FIFO on the cycle a pop happens
    auto_uart = 1'b0;
    bsy_man = 1'b1;
    for (int k = 0; k < 16; k++) push(8'h20 + k[7:0], 1);
    chk("full2", full, 1);
    bsy_man = 1'b0;
    wr = 1'b1;
    dat = 8'h99;
    @(negedge clk);
    wr = 1'b0;
    bsy_man = 1'b1;
    chk("popfull_strobe", uart_wr, 1);
    chk("popfull_count", count, 15);
    chk("popfull_ovf", ovf, 1);
    @(negedge clk);
    chk("popfull_hold", count, 15);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_clr2", ovf, 0);
    auto_uart = 1'b1;
    wait_drain("drain15", 400);

    // 5: reset on the strobe cycle
    auto_uart = 1'b0;
    bsy_man = 1'b1;
    push(8'hA1, 1);
    push(8'hA2, 1);
    push(8'hA3, 1);
    bsy_man = 1'b0;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (uart_wr) found = 1;
    end
    chk("rst_mid_found", int'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk("rst_mid_wr", uart_wr, 0);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_empty", empty, 1);
    s0 = n_strobe;
    repeat (20) @(negedge clk);
    chk("rst_mid_quiet", n_strobe - s0, 0);

    // 6: LF handling
    auto_uart = 1'b1;
    exp_q.push_back(8'h41);
`ifdef UART_TX_FIFO_CRLF_EN
    exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(8'h0A);
    push(8'h41, 0);
    push(8'h0A, 0);
    s0 = n_strobe;
    wait_drain("crlf_drain", 200);
`ifdef UART_TX_FIFO_CRLF_EN
    chk("crlf_strobes", n_strobe - s0, 3);
`else
    chk("crlf_strobes", n_strobe - s0, 2);
`endif
    chk("final_empty", empty, 1);
    chk("final_ovf", ovf, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
